// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one uart_tx.
// Each requester presents a byte with a valid bit. The winner's byte is handed to
// uart_tx, and the requester receives a one-cycle ack once the byte has gone out.
// After reset, a drain period lets any byte already in uart_tx finish before the
// next grant.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   DRAIN    | after reset: wait out one full uart frame so uart_tx is back in LISTEN
//   IDLE     | waiting for a request while uart_tx reports not-complete
//   SEND     | byte handed to uart_tx, txSend held high until txComplete
//   RELEASE  | ack issued, waiting for uart_tx to drop txComplete
//
// All outputs are registered. The next-state logic below computes the next value
// of every output, and the state register captures those values on the clock edge.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 139,
    parameter int WORDBITS     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    output logic [NUM_REQ-1:0]         reqAck,
    output logic [7:0]                 txData,
    output logic                       txSend,
    input  logic                       txComplete,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic                       busy
);

    localparam int ID_W         = $clog2(NUM_REQ);
    // One full frame (start + WORDBITS + stop) plus margin for the handshake return.
    localparam int DRAIN_CYCLES = (WORDBITS + 2) * CLKS_PER_BIT + 2;
    localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_DRAIN   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]   drain_cnt_nxt;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    last_grant_nxt;
    logic [ID_W-1:0]    grant_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [7:0]         data_nxt;
    logic               send_nxt;
    logic               busy_nxt;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W:0]      search_pos;

    // Round-robin search: start one past the last grant, search upward and wrap at NUM_REQ.
    // The lowest candidate in that order with its valid bit set wins.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        search_pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            search_pos = {1'b0, last_grant} + (ID_W + 1)'(k);
            if (search_pos >= NUM_REQ_EXT) begin
                search_pos = search_pos - NUM_REQ_EXT;
            end
            if (!win_found && reqValid[search_pos[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = search_pos[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic. txSend and reqAck default low, so each is
    // driven high only in the state where it applies.
    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        last_grant_nxt = last_grant;
        grant_nxt      = grantId;
        data_nxt       = txData;
        send_nxt       = 1'b0;
        ack_nxt        = '0;
        case (state)
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = ST_IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // A high txComplete means uart_tx has not finished its handshake yet.
                if (!txComplete && win_found) begin
                    state_nxt      = ST_SEND;
                    send_nxt       = 1'b1;
                    data_nxt       = reqData[{win_idx, 3'b000} +: 8];
                    grant_nxt      = win_idx;
                    last_grant_nxt = win_idx;
                end
            end
            ST_SEND: begin
                if (txComplete) begin
                    state_nxt        = ST_RELEASE;
                    ack_nxt[grantId] = 1'b1;
                end else begin
                    send_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!txComplete) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_DRAIN;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers. Reset forces the drain state and drops any transfer
    // in flight, so no ack is issued for it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_DRAIN;
            drain_cnt  <= '0;
            txSend     <= 1'b0;
            txData     <= '0;
            reqAck     <= '0;
            busy       <= 1'b1;
            grantId    <= '0;
            last_grant <= LAST_ID;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_cnt_nxt;
            txSend     <= send_nxt;
            txData     <= data_nxt;
            reqAck     <= ack_nxt;
            busy       <= busy_nxt;
            grantId    <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx and serial receiver, reference model,
// directed scenarios and a randomized requester phase.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int CPB       = 4;
    localparam int WB        = 8;
    localparam int DRAIN_LEN = (WB + 2) * CPB + 2;

    localparam int P_DRAIN   = 0;
    localparam int P_IDLE    = 1;
    localparam int P_SEND    = 2;
    localparam int P_RELEASE = 3;

    logic                 clock      = 1'b0;
    logic                 reset      = 1'b1;
    logic [NUM_REQ-1:0]   reqValid   = '0;
    logic [8*NUM_REQ-1:0] reqData    = '0;
    logic [NUM_REQ-1:0]   reqAck;
    logic [7:0]           txData;
    logic                 txSend;
    logic                 txComplete = 1'b0;
    logic [1:0]           grantId;
    logic                 busy;
    logic                 txOut      = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CLKS_PER_BIT(CPB),
        .WORDBITS    (WB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqAck    (reqAck),
        .txData    (txData),
        .txSend    (txSend),
        .txComplete(txComplete),
        .grantId   (grantId),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected event never occurred (t=%0t)", name, $time);
    endtask

    // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit, then raise
    // sendComplete and hold it until send drops.
    int         u_st  = 0;
    int         u_cnt = 0;
    int         u_idx = 0;
    logic [7:0] u_sh  = '0;
    always @(posedge clock) begin
        case (u_st)
            0: if (txSend === 1'b1) begin
                u_sh  <= txData;
                u_st  <= 1;
                u_idx <= 0;
                u_cnt <= 0;
                txOut <= 1'b0;
            end
            1: begin
                if (u_cnt == CPB - 1) begin
                    u_cnt <= 0;
                    if (u_idx == 9) begin
                        u_st       <= 2;
                        txComplete <= 1'b1;
                    end else begin
                        u_idx <= u_idx + 1;
                        txOut <= (u_idx == 8) ? 1'b1 : u_sh[u_idx[2:0]];
                    end
                end else begin
                    u_cnt <= u_cnt + 1;
                end
            end
            default: if (txSend !== 1'b1) begin
                txComplete <= 1'b0;
                u_st       <= 0;
            end
        endcase
    end

    // Reference model: a transaction view of the arbiter built from its behavioural rules.
    logic [7:0] exp_q[$];
    bit                 m_active = 1'b0;
    int                 m_phase  = P_DRAIN;
    int                 m_left   = 0;
    bit                 m_send   = 1'b0;
    logic [7:0]         m_data   = '0;
    int                 m_grant  = 0;
    int                 m_last   = NUM_REQ - 1;
    logic [NUM_REQ-1:0] m_ack    = '0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        int order[NUM_REQ];
        for (int k = 0; k < NUM_REQ; k++) order[k] = (last + 1 + k) % NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_active <= 1'b1;
            m_phase  <= P_DRAIN;
            m_left   <= DRAIN_LEN;
            m_send   <= 1'b0;
            m_data   <= '0;
            m_grant  <= 0;
            m_last   <= NUM_REQ - 1;
            m_ack    <= '0;
        end else if (m_active) begin
            m_ack <= '0;
            case (m_phase)
                P_DRAIN: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= P_IDLE;
                end
                P_IDLE: if (!txComplete && rr_pick(reqValid, m_last) >= 0) begin
                    m_phase <= P_SEND;
                    m_send  <= 1'b1;
                    m_data  <= reqData[8*rr_pick(reqValid, m_last) +: 8];
                    m_grant <= rr_pick(reqValid, m_last);
                    m_last  <= rr_pick(reqValid, m_last);
                    exp_q.push_back(reqData[8*rr_pick(reqValid, m_last) +: 8]);
                end
                P_SEND: if (txComplete) begin
                    m_send  <= 1'b0;
                    m_ack   <= NUM_REQ'(1) << m_grant;
                    m_phase <= P_RELEASE;
                end
                default: if (!txComplete) m_phase <= P_IDLE;
            endcase
        end
    end

    // Cycle compare of every DUT output against the model.
    always @(negedge clock) begin
        if (m_active) begin
            chk("busy", busy, (m_phase != P_IDLE));
            chk("txSend", txSend, m_send);
            chk("txData", txData, m_data);
            chk("grantId", grantId, m_grant);
            chk("reqAck", reqAck, m_ack);
        end
    end

    // Serial receiver: samples each bit mid-period and checks bytes in grant order.
    logic [9:0] rx_frame = '1;
    logic [7:0] rx_last  = '0;
    int         rx_count = 0;
    initial begin
        forever begin
            @(negedge clock);
            if (txOut === 1'b0) begin
                for (int j = 0; j < 10; j++) begin
                    repeat ((j == 0) ? 2 : CPB) @(negedge clock);
                    rx_frame[j] = txOut;
                end
                rx_last = rx_frame[8:1];
                rx_count++;
                chk("rx_start_bit", rx_frame[0], 1'b0);
                chk("rx_stop_bit", rx_frame[9], 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_byte: got 0x%0h, expected no byte on the line", rx_last);
                end else begin
                    chk("rx_byte", rx_last, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_grant(output logic [7:0] gdata, output int gid);
        int n;
        n     = 0;
        gdata = '0;
        gid   = -1;
        while (txSend !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (txSend !== 1'b1) fail_timeout("wait_grant");
        else begin
            gdata = txData;
            gid   = int'(grantId);
        end
    endtask

    task automatic wait_ack(output logic [NUM_REQ-1:0] a, output int n);
        n = 0;
        a = '0;
        while (reqAck === '0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (reqAck === '0) fail_timeout("wait_ack");
        else a = reqAck;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy !== 1'b0) fail_timeout("wait_idle");
    endtask

    task automatic do_reset();
        reqValid = '0;
        repeat (60) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]         gd;
        logic [NUM_REQ-1:0] a;
        int                 gid;
        int                 n;
        int                 rx_before;
        bit                 ack_seen;

        // Reset values, then drain length.
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 1'b1);
        chk("rst_txSend", txSend, 1'b0);
        chk("rst_txData", txData, 8'h00);
        chk("rst_reqAck", reqAck, 4'b0000);
        chk("rst_grantId", grantId, 2'd0);
        reset = 1'b0;
        n     = 0;
        while (n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (busy === 1'b0) break;
        end
        chk("drain_cycles", n, 42);
        @(negedge clock);

        // Single requester 0 with 8'hA5.
        reqData[7:0] = 8'hA5;
        reqValid     = 4'b0001;
        wait_grant(gd, gid);
        chk("a5_grant", gid, 0);
        chk("a5_data", gd, 8'hA5);
        wait_ack(a, n);
        reqValid = '0;
        chk("a5_ack", a, 4'b0001);
        chk("a5_send_cycles", n, 42);
        chk("a5_frame", rx_frame, 10'b1101001010);
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("a5_ack_to_idle", n, 2);

        // All four requesters held: order 0,1,2,3,0.
        do_reset();
        wait_idle();
        for (int i = 0; i < NUM_REQ; i++) reqData[8*i +: 8] = 8'h10 + 8'(i);
        reqValid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(gd, gid);
            chk("rr_grant", gid, g % 4);
            chk("rr_data", gd, 8'h10 + 8'(g % 4));
            wait_ack(a, n);
            chk("rr_ack", a, 4'b0001 << (g % 4));
        end
        reqValid = '0;

        // Wrap: after a grant to 3, requesters 0 and 3 -> 0 then 3.
        do_reset();
        wait_idle();
        reqData[31:24] = 8'h3A;
        reqData[7:0]   = 8'h0B;
        reqValid       = 4'b1000;
        wait_grant(gd, gid);
        chk("wrap_first", gid, 3);
        wait_ack(a, n);
        reqValid = 4'b1001;
        wait_grant(gd, gid);
        chk("wrap_grant0", gid, 0);
        chk("wrap_data0", gd, 8'h0B);
        wait_ack(a, n);
        chk("wrap_ack0", a, 4'b0001);
        reqValid = 4'b1000;
        wait_grant(gd, gid);
        chk("wrap_grant3", gid, 3);
        chk("wrap_data3", gd, 8'h3A);
        wait_ack(a, n);
        reqValid = '0;
        repeat (5) @(negedge clock);

        // Reset pulse during the uart data bits.
        reqData[15:8] = 8'h3C;
        reqValid      = 4'b0010;
        wait_grant(gd, gid);
        chk("mid_grant", gid, 1);
        rx_before = rx_count;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_txSend", txSend, 1'b0);
        chk("mid_busy", busy, 1'b1);
        chk("mid_ack", reqAck, 4'b0000);
        ack_seen = 1'b0;
        n        = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
            if (reqAck !== '0) ack_seen = 1'b1;
        end
        chk("mid_no_ack", ack_seen, 1'b0);
        chk("mid_byte_finished", rx_count, rx_before + 1);
        wait_grant(gd, gid);
        chk("mid_regrant", gid, 1);
        chk("mid_redata", gd, 8'h3C);
        wait_ack(a, n);
        chk("mid_reack", a, 4'b0010);
        reqValid = '0;
        repeat (5) @(negedge clock);

        // Data changed after grant has no effect.
        reqData[15:8] = 8'h55;
        reqValid      = 4'b0010;
        wait_grant(gd, gid);
        reqData[15:8] = 8'hFF;
        chk("late_grant", gid, 1);
        wait_ack(a, n);
        reqValid = '0;
        chk("late_txData", txData, 8'h55);
        repeat (5) @(negedge clock);
        chk("late_rx", rx_last, 8'h55);

        // Randomized requesters against the model.
        do_reset();
        wait_idle();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqValid[i] && reqAck[i]) begin
                    if ($urandom_range(0, 1) == 0) reqValid[i] = 1'b0;
                    else reqData[8*i +: 8] = 8'($urandom);
                end else if (!reqValid[i]) begin
                    if ($urandom_range(0, 19) == 0) begin
                        reqValid[i]        = 1'b1;
                        reqData[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    reqData[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 199) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
        end
        reqValid = '0;
        repeat (120) @(negedge clock);
        chk("tx_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter CLKS_PER_BIT, default 139, bit period of the attached uart_tx, used only for the drain timer.
REQ-003 Parameter WORDBITS, default 8, serial word length of the attached uart_tx.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqValid  input  NUM_REQ  bit i high = requester i has a byte to send.
REQ-007 reqData  input  8*NUM_REQ  byte of requester i at bits [8*i+7 : 8*i].
REQ-008 reqAck  output  NUM_REQ  one-cycle pulse on bit i when requester i's byte has finished transmitting.
REQ-009 txData  output  8  byte to uart_tx txIn.
REQ-010 txSend  output  1  to uart_tx send.
REQ-011 txComplete  input  1  from uart_tx sendComplete.
REQ-012 grantId  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: DRAIN, IDLE, SEND, RELEASE; all outputs are registered.
REQ-015 DRAIN: txSend=0; counter runs (WORDBITS+2)*CLKS_PER_BIT+2 cycles, then goes to IDLE; guarantees an in-flight uart_tx byte completes and returns to LISTEN.
REQ-016 IDLE: if txComplete=0 and any reqValid bit is set, select a winner round-robin, starting at (lastGrant+1) mod NUM_REQ and searching upward with wrap.
REQ-017 On grant (same edge): latch the winner's byte into txData, set grantId and lastGrant to the winner, assert txSend, go to SEND.
REQ-018 IDLE with no reqValid, or with txComplete=1: stay in IDLE; txSend=0.
REQ-019 SEND: hold txSend=1 and txData stable until txComplete=1 is sampled.
REQ-020 On that edge: txSend<=0, reqAck[grantId]<=1 for exactly one cycle, go to RELEASE.
REQ-021 RELEASE: txSend=0; wait for txComplete=0, then go to IDLE.
REQ-022 Minimum spacing between successive grants is therefore uart_tx's handshake return plus one IDLE cycle.
REQ-023 reqData is sampled only on the grant edge; later changes have no effect on the byte in flight.
REQ-024 Dropping reqValid[i] after grant does not abort the transfer; the ack is still issued.
REQ-025 Requesters hold reqValid until reqAck; a requester still valid after its ack competes again at lowest priority.
REQ-026 Only one reqAck bit is ever high; reqAck is all-zero outside the SEND->RELEASE edge.
REQ-027 Round-robin wrap: after a grant to NUM_REQ-1, search starts at 0.
REQ-028 A single persistent requester is granted back-to-back with no starvation penalty.
REQ-029 Drain counter width is clog2((WORDBITS+2)*CLKS_PER_BIT+3); no overflow.

Reset
REQ-030 reset high on any edge, including mid-SEND, forces state=DRAIN, counter=0, txSend=0, txData=0, reqAck=0, busy=1, grantId=0, lastGrant=NUM_REQ-1.
REQ-031 No reqAck is issued for a transfer interrupted by reset.
REQ-032 Held reset keeps the block in the REQ-030 state; the drain count starts on the first cycle after reset falls.

Verification (bench uses CLKS_PER_BIT=4, WORDBITS=8 with a real uart_tx attached)
REQ-033 Release reset -> busy=1, txSend=0 for exactly 42 cycles, then IDLE with busy=0.
REQ-034 reqValid=4'b0001, reqData[7:0]=8'hA5 -> txSend=1 and txData=8'hA5; txOut serial pattern is 0,1,0,1,0,0,1,0,1,1 (LSB first); reqAck=4'b0001 for one cycle; busy falls after txComplete falls.
REQ-035 reqValid=4'b1111 held with bytes 8'h10,8'h11,8'h12,8'h13 -> grants in order 0,1,2,3,0; ack order matches; txData values are 8'h10..8'h13.
REQ-036 After a grant to 3, reqValid=4'b1001 -> next grant is 0, then 3.
REQ-037 Assert reset for 1 cycle mid-SEND (during uart DATA) -> txSend=0 next cycle, no reqAck; the uart byte finishes during DRAIN; the next grant transmits cleanly with the correct byte.
REQ-038 Change reqData[15:8] from 8'h55 to 8'hFF one cycle after grant to 1 -> transmitted byte is 8'h55.
